// File: rtl/am2940_dma_sequencer.sv
// Sequencer that programs an am2940 DMA address generator for one block
// transfer per request, then gates its counter carries with memory word-ready.
module am2940_dma_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_addr,
  input  logic [WIDTH-1:0] word_count,
  input  logic             abort,
  input  logic             mem_ready,
  input  logic             dma_done,
  output logic [2:0]       instr,
  output logic [WIDTH-1:0] dma_data,
  output logic             acineg,
  output logic             wcineg,
  output logic             busy,
  output logic             xfer_done,
  output logic             aborted,
  output logic [CNT_W-1:0] words_xfer
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_CTRL, S_LD_ADDR, S_LD_WC, S_RUN, S_FINISH
  } state_t;

  localparam logic [2:0] I_WR_CTRL = 3'b000;
  localparam logic [2:0] I_RD_CTRL = 3'b001;
  localparam logic [2:0] I_LD_ADDR = 3'b101;
  localparam logic [2:0] I_LD_WC   = 3'b110;
  localparam logic [2:0] I_ENABLE  = 3'b111;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_mode;
  logic             r_dir;
  logic [WIDTH-1:0] r_start_addr;
  logic [WIDTH-1:0] r_word_count;
  logic [CNT_W-1:0] r_words;
  logic             r_aborted;
  logic             w_abort_ev;
  logic             w_accept;
  logic             w_count;

  assign w_accept   = (r_state == S_IDLE) && req;
  assign w_abort_ev = abort && (r_state inside {S_WR_CTRL, S_LD_ADDR, S_LD_WC, S_RUN});
  // Abort wins over a word arriving in the same cycle, so that word is dropped.
  assign w_count    = (r_state == S_RUN) && mem_ready && !abort;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (req) w_next = S_WR_CTRL;
      S_WR_CTRL: w_next = abort ? S_IDLE : S_LD_ADDR;
      S_LD_ADDR: w_next = abort ? S_IDLE : S_LD_WC;
      S_LD_WC:   w_next = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)                      w_next = S_IDLE;
        else if (mem_ready && dma_done) w_next = S_FINISH;
      end
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    instr     = I_RD_CTRL;
    dma_data  = '0;
    acineg    = 1'b1;
    wcineg    = 1'b1;
    busy      = (r_state != S_IDLE);
    xfer_done = 1'b0;
    case (r_state)
      S_WR_CTRL: begin
        instr         = I_WR_CTRL;
        dma_data[2:0] = {r_dir, r_mode};
      end
      S_LD_ADDR: begin
        instr    = I_LD_ADDR;
        dma_data = r_start_addr;
      end
      S_LD_WC: begin
        instr    = I_LD_WC;
        dma_data = r_word_count;
      end
      S_RUN: begin
        instr  = I_ENABLE;
        acineg = ~mem_ready;
        wcineg = ~mem_ready;
      end
      S_FINISH:  xfer_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode       <= '0;
      r_dir        <= 1'b0;
      r_start_addr <= '0;
      r_word_count <= '0;
      r_words      <= '0;
      r_aborted    <= 1'b0;
    end else begin
      r_aborted <= w_abort_ev;
      if (w_accept) begin
        r_mode       <= mode;
        r_dir        <= dir;
        r_start_addr <= start_addr;
        r_word_count <= word_count;
        r_words      <= '0;
      end else if (w_count) begin
        r_words <= r_words + CNT_W'(1);
      end
    end
  end

  assign aborted    = r_aborted;
  assign words_xfer = r_words;

endmodule

// File: tb/tb_am2940_dma_sequencer.sv
// Directed bench for am2940_dma_sequencer: inputs change and outputs are
// sampled on the falling edge, with hand-computed expected values.
module tb_am2940_dma_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [1:0] mode;
  logic       dir;
  logic [7:0] start_addr;
  logic [7:0] word_count;
  logic       abort;
  logic       mem_ready;
  logic       dma_done;
  logic [2:0] instr;
  logic [7:0] dma_data;
  logic       acineg;
  logic       wcineg;
  logic       busy;
  logic       xfer_done;
  logic       aborted;
  logic [7:0] words_xfer;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  am2940_dma_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .dir(dir),
    .start_addr(start_addr), .word_count(word_count), .abort(abort),
    .mem_ready(mem_ready), .dma_done(dma_done), .instr(instr),
    .dma_data(dma_data), .acineg(acineg), .wcineg(wcineg), .busy(busy),
    .xfer_done(xfer_done), .aborted(aborted), .words_xfer(words_xfer)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_desc(input logic [1:0] m, input logic d, input logic [7:0] a,
                          input logic [7:0] w);
    mode = m; dir = d; start_addr = a; word_count = w;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; abort = 1'b0; mem_ready = 1'b0; dma_done = 1'b0;
    set_desc(2'd0, 1'b0, 8'h00, 8'h00);
    tick(); tick();
    check("rst_instr", 32'(instr), 32'h1);
    check("rst_data", 32'(dma_data), 32'h0);
    check("rst_carries", 32'({acineg, wcineg}), 32'h3);
    check("rst_flags", 32'({busy, xfer_done, aborted}), 32'h0);
    check("rst_words", 32'(words_xfer), 32'h0);
    rst_n = 1'b1;
    tick();

    // Programming sequence; descriptor changes after acceptance must be ignored.
    set_desc(2'd2, 1'b0, 8'h02, 8'h01); req = 1'b1;
    tick();
    check("wrc_instr", 32'(instr), 32'h0);
    check("wrc_data", 32'(dma_data), 32'h02);
    check("wrc_busy", 32'(busy), 32'h1);
    req = 1'b0; set_desc(2'd3, 1'b1, 8'hFF, 8'hFF);
    tick();
    check("lda_instr", 32'(instr), 32'h5);
    check("lda_data", 32'(dma_data), 32'h02);
    tick();
    check("ldw_instr", 32'(instr), 32'h6);
    check("ldw_data", 32'(dma_data), 32'h01);
    tick();
    check("run_instr", 32'(instr), 32'h7);
    check("run_data", 32'(dma_data), 32'h0);
    check("run_idle_carries", 32'({acineg, wcineg}), 32'h3);

    // Carry gating follows ~mem_ready; toggle 1,0,1.
    mem_ready = 1'b1; #1;
    check("gate_carries_on", 32'({acineg, wcineg}), 32'h0);
    tick();
    check("gate_words1", 32'(words_xfer), 32'h1);
    mem_ready = 1'b0; #1;
    check("gate_carries_off", 32'({acineg, wcineg}), 32'h3);
    tick();
    check("gate_words_hold", 32'(words_xfer), 32'h1);
    mem_ready = 1'b1;
    tick();
    check("gate_words2", 32'(words_xfer), 32'h2);
    mem_ready = 1'b0; dma_done = 1'b1;
    tick();
    check("done_no_ready_instr", 32'(instr), 32'h7);
    check("done_no_ready_flags", 32'({busy, xfer_done}), 32'h2);

    // Asynchronous reset mid-RUN.
    dma_done = 1'b0; rst_n = 1'b0; #1;
    check("arst_instr", 32'(instr), 32'h1);
    check("arst_carries", 32'({acineg, wcineg}), 32'h3);
    check("arst_flags", 32'({busy, xfer_done, aborted}), 32'h0);
    check("arst_words", 32'(words_xfer), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_flags", 32'({busy, xfer_done, aborted}), 32'h0);

    // Normal completion with word_count=4; mem_ready during LD_WC is not counted.
    set_desc(2'd0, 1'b0, 8'h40, 8'h04); req = 1'b1;
    tick();
    req = 1'b0;
    tick(); tick();
    mem_ready = 1'b1; #1;
    check("ldw_carries_inactive", 32'({acineg, wcineg}), 32'h3);
    tick();
    check("cmp_words0", 32'(words_xfer), 32'h0);
    tick();
    check("cmp_words1", 32'(words_xfer), 32'h1);
    tick(); tick();
    check("cmp_words3", 32'(words_xfer), 32'h3);
    dma_done = 1'b1;
    tick();
    check("fin_xfer_done", 32'(xfer_done), 32'h1);
    check("fin_words", 32'(words_xfer), 32'h4);
    check("fin_instr", 32'(instr), 32'h1);
    check("fin_carries", 32'({acineg, wcineg}), 32'h3);
    check("fin_busy", 32'(busy), 32'h1);
    mem_ready = 1'b0; dma_done = 1'b0;
    tick();
    check("idle_after_fin", 32'({busy, xfer_done, aborted}), 32'h0);
    check("idle_words_hold", 32'(words_xfer), 32'h4);

    // Abort with a coincident word after three counted words.
    set_desc(2'd1, 1'b0, 8'h80, 8'h09); req = 1'b1;
    tick();
    check("abt_cleared", 32'(words_xfer), 32'h0);
    req = 1'b0;
    tick(); tick(); tick();
    mem_ready = 1'b1;
    tick(); tick(); tick();
    check("abt_words3", 32'(words_xfer), 32'h3);
    abort = 1'b1; dma_done = 1'b1;
    tick();
    check("abt_pulse", 32'(aborted), 32'h1);
    check("abt_words", 32'(words_xfer), 32'h3);
    check("abt_state", 32'({busy, xfer_done}), 32'h0);
    check("abt_instr", 32'(instr), 32'h1);
    abort = 1'b0; mem_ready = 1'b0; dma_done = 1'b0;
    tick();
    check("abt_pulse_end", 32'(aborted), 32'h0);

    // Back-to-back with req held; second descriptor presented during FINISH.
    set_desc(2'd1, 1'b1, 8'h10, 8'h01); req = 1'b1;
    tick();
    check("b2b_a_ctrl", 32'(dma_data), 32'h05);
    tick(); tick(); tick();
    mem_ready = 1'b1; dma_done = 1'b1;
    tick();
    check("b2b_a_done", 32'(xfer_done), 32'h1);
    check("b2b_a_words", 32'(words_xfer), 32'h1);
    mem_ready = 1'b0; dma_done = 1'b0;
    set_desc(2'd3, 1'b0, 8'h20, 8'h05);
    tick();
    check("b2b_idle_busy", 32'(busy), 32'h0);
    check("b2b_idle_words", 32'(words_xfer), 32'h1);
    tick();
    check("b2b_b_busy", 32'(busy), 32'h1);
    check("b2b_b_instr", 32'(instr), 32'h0);
    check("b2b_b_ctrl", 32'(dma_data), 32'h03);
    check("b2b_b_words", 32'(words_xfer), 32'h0);
    req = 1'b0;
    tick();
    check("b2b_b_addr", 32'(dma_data), 32'h20);
    tick();
    check("b2b_b_wc", 32'(dma_data), 32'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
